uart_rx_frame_decoder: RTL

//  Receiving end of the serial link: consumes the TX_OUT line driven by the UART transmitter
//  and rebuilds each frame (start, 8 data LSB-first, optional parity, stop) into P_DATA.

---
 rtl/uart_pkg.sv | 26 ++
 rtl/uart_rx_sampler.sv | 80 ++++++++
 rtl/uart_rx_frame_decoder.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// uart_pkg
//   Shared UART types and helpers, used by both the transmitter and the
//   receiver.
//   rx_state_e  : receiver frame FSM states
//   PAR_EVEN/ODD: encodings of the PAR_TYP input
//   calc_parity : parity bit that goes with a data word for a given parity type
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } rx_state_e;

   localparam logic PAR_EVEN = 1'b0;
   localparam logic PAR_ODD  = 1'b1;

   // Callers zero-extend their data word to 32 bits.
   // Zero bits do not change the XOR, so any data width up to 32 works.
   function automatic logic calc_parity(input logic [31:0] data, input logic typ);
      return (^data) ^ (typ == PAR_ODD);
   endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler
//   Synchronizes the asynchronous serial line and times each bit period.
//   Within each bit it takes three samples around the bit centre and returns
//   their majority as the bit value.
//   clk, rst_n : clock, asynchronous active-low reset
//   rx_in      : raw serial line (idle high)
//   count_en   : 1 while a frame is in progress; edge_cnt is held at 0 otherwise
//   rx_s       : synchronized line
//   bit_val    : majority-voted bit value; valid when bit_done is 1
//   bit_done   : one-cycle pulse on the last clock of each bit period
module uart_rx_sampler #(
   parameter int PRESCALE    = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic rx_in,
   input  logic count_en,
   output logic rx_s,
   output logic bit_val,
   output logic bit_done
);

   localparam int CNT_W = $clog2(PRESCALE);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PRESCALE - 1);
   // With PRESCALE=4 the third sample point falls on the wrap cycle itself.
   // In that case the live line value is voted instead of a stored sample.
   localparam bit LIVE_THIRD = ((PRESCALE / 2 + 1) == (PRESCALE - 1));

   logic [SYNC_STAGES-1:0] sync_reg;
   logic [CNT_W-1:0]       edge_cnt_reg;
   logic [2:0]             smp_reg;
   logic [2:0]             smp_hit;
   logic                   third;

   // The synchronizer resets to 1 so that reset release never looks like a start bit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_reg <= '1;
      end else begin
         sync_reg <= {sync_reg[SYNC_STAGES-2:0], rx_in};
      end
   end

   assign rx_s = sync_reg[SYNC_STAGES-1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         edge_cnt_reg <= '0;
      end else if (!count_en || edge_cnt_reg == LAST_CNT) begin
         edge_cnt_reg <= '0;
      end else begin
         edge_cnt_reg <= edge_cnt_reg + CNT_W'(1);
      end
   end

   // The sample points are PRESCALE/2-1, PRESCALE/2 and PRESCALE/2+1.
   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_point
         localparam logic [CNT_W-1:0] POINT = CNT_W'(PRESCALE / 2 - 1 + gi);
         assign smp_hit[gi] = count_en && (edge_cnt_reg == POINT);
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         smp_reg <= '1;
      end else begin
         for (int i = 0; i < 3; i++) begin
            if (smp_hit[i]) smp_reg[i] <= rx_s;
         end
      end
   end

   assign third    = LIVE_THIRD ? rx_s : smp_reg[2];
   assign bit_val  = (smp_reg[0] & smp_reg[1]) | (smp_reg[0] & third) | (smp_reg[1] & third);
   assign bit_done = count_en && (edge_cnt_reg == LAST_CNT);

endmodule

// File: rtl/uart_rx_frame_decoder.sv
// uart_rx_frame_decoder
//   UART receiver. Rebuilds frames of the form start, DATA_WIDTH data bits
//   (LSB first), optional parity and stop into P_DATA.
//   clk, reset : clock, asynchronous active-low reset
//   RX_IN      : serial line, idle high, asynchronous to clk
//   PAR_EN     : 1 = frames carry a parity bit (latched at start detection)
//   PAR_TYP    : 0 = even, 1 = odd parity (latched at start detection)
//   P_DATA     : last cleanly received word; takes its new value in the DATA_VALID cycle
//   DATA_VALID : one-cycle pulse, frame received without error
//   PAR_ERR    : one-cycle pulse, parity mismatch
//   STP_ERR    : one-cycle pulse, stop bit sampled as 0
//   Busy       : 1 while a frame is being received
module uart_rx_frame_decoder
   import uart_pkg::*;
#(
   parameter int PRESCALE    = 8,
   parameter int DATA_WIDTH  = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  RX_IN,
   input  logic                  PAR_EN,
   input  logic                  PAR_TYP,
   output logic [DATA_WIDTH-1:0] P_DATA,
   output logic                  DATA_VALID,
   output logic                  PAR_ERR,
   output logic                  STP_ERR,
   output logic                  Busy
);

   localparam int BC_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [BC_W-1:0] LAST_BIT = BC_W'(DATA_WIDTH - 1);

   rx_state_e              state_reg, state_next;
   logic [DATA_WIDTH-1:0]  shift_reg, shift_next;
   logic [DATA_WIDTH-1:0]  p_data_reg, p_data_next;
   logic [BC_W-1:0]        bit_cnt_reg, bit_cnt_next;
   logic                   par_en_reg, par_en_next;
   logic                   par_typ_reg, par_typ_next;
   logic                   par_err_reg, par_err_next;
   logic                   start_take;

   logic rx_s;
   logic bit_val;
   logic bit_done;

   uart_rx_sampler #(
      .PRESCALE    (PRESCALE),
      .SYNC_STAGES (SYNC_STAGES)
   ) u_sampler (
      .clk      (clk),
      .rst_n    (reset),
      .rx_in    (RX_IN),
      .count_en (Busy),
      .rx_s     (rx_s),
      .bit_val  (bit_val),
      .bit_done (bit_done)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg   <= IDLE;
         shift_reg   <= '0;
         p_data_reg  <= '0;
         bit_cnt_reg <= '0;
         par_en_reg  <= 1'b0;
         par_typ_reg <= 1'b0;
         par_err_reg <= 1'b0;
      end else begin
         state_reg   <= state_next;
         shift_reg   <= shift_next;
         p_data_reg  <= p_data_next;
         bit_cnt_reg <= bit_cnt_next;
         par_en_reg  <= par_en_next;
         par_typ_reg <= par_typ_next;
         par_err_reg <= par_err_next;
      end
   end

   always_comb begin
      state_next   = state_reg;
      shift_next   = shift_reg;
      p_data_next  = p_data_reg;
      bit_cnt_next = bit_cnt_reg;
      par_en_next  = par_en_reg;
      par_typ_next = par_typ_reg;
      par_err_next = par_err_reg;
      start_take   = 1'b0;
      DATA_VALID   = 1'b0;
      PAR_ERR      = 1'b0;
      STP_ERR      = 1'b0;

      unique case (state_reg)
         IDLE: begin
            if (!rx_s) begin
               state_next = START;
               start_take = 1'b1;
            end
         end

         START: begin
            if (bit_done) begin
               // If the start bit votes high it was a glitch: drop it silently.
               state_next   = bit_val ? IDLE : DATA;
               bit_cnt_next = '0;
            end
         end

         DATA: begin
            if (bit_done) begin
               shift_next = {bit_val, shift_reg[DATA_WIDTH-1:1]};
               if (bit_cnt_reg == LAST_BIT) begin
                  bit_cnt_next = '0;
                  state_next   = par_en_reg ? PARITY : STOP;
               end else begin
                  bit_cnt_next = bit_cnt_reg + BC_W'(1);
               end
            end
         end

         PARITY: begin
            if (bit_done) begin
               if (bit_val != calc_parity(32'(shift_reg), par_typ_reg)) par_err_next = 1'b1;
               state_next = STOP;
            end
         end

         STOP: begin
            if (bit_done) begin
               STP_ERR    = !bit_val;
               PAR_ERR    = par_err_reg;
               DATA_VALID = bit_val && !par_err_reg;
               if (DATA_VALID) p_data_next = shift_reg;
               // rx_s at the wrap is already the first sample of the next bit.
               // If it is low, go straight into START so back-to-back frames
               // (and a held-low break line) repeat exactly once per frame length.
               if (!rx_s) begin
                  state_next = START;
                  start_take = 1'b1;
               end else begin
                  state_next = IDLE;
               end
            end
         end

         default: state_next = IDLE;
      endcase

      if (start_take) begin
         par_en_next  = PAR_EN;
         par_typ_next = PAR_TYP;
         par_err_next = 1'b0;
      end
   end

   // The new word is already visible in the DATA_VALID cycle.
   assign P_DATA = DATA_VALID ? shift_reg : p_data_reg;
   assign Busy   = (state_reg != IDLE);

endmodule
